id_stage: RTL and testbench

//  Instruction-decode stage feeding the EX block: the producer side of the EX input bus.

---
 rtl/mips_pkg.sv | 67 ++++++
 rtl/id_stage_if.sv | 20 ++
 rtl/mips_regfile.sv | 45 ++++
 rtl/id_stage.sv | 104 ++++++++++
 tb/tb_id_stage.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// MIPS opcode/funct constants and the ID/EX latch layout shared by the decode stage
// and its EX-side consumers.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LWL   = 6'h22;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;

    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_SRA   = 6'h03;
    localparam logic [5:0] F_JR    = 6'h08;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1a;
    localparam logic [5:0] F_DIVU  = 6'h1b;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_SLT   = 6'h2a;

    localparam logic [4:0] REG_RA = 5'd31;

    typedef struct packed {
        logic [31:0] rdata1;
        logic [31:0] rdata2;
        logic [5:0]  alu;
        logic [5:0]  op;
        logic [31:0] ed32;
        logic [25:0] jadr;
        logic [31:0] next_pc;
        logic [4:0]  dst;
        logic        reg_write;
        logic        valid;
    } idex_t;

    // Opcode-level write intent; the caller still masks writes to $0.
    function automatic logic writes_reg(logic [5:0] op, logic [5:0] funct);
        logic w;
        w = 1'b0;
        case (op)
            OP_RTYPE: w = !(funct inside {F_JR, F_MTHI, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU});
            OP_JAL:   w = 1'b1;
            default:  w = ((op >= OP_ADDI) && (op <= OP_LUI)) || ((op >= OP_LB) && (op <= OP_LHU));
        endcase
        return w;
    endfunction

    function automatic logic is_zext_imm(logic [5:0] op);
        return op inside {OP_ANDI, OP_ORI, OP_XORI, OP_LUI};
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// ID -> EX operand/control bus; the decode stage is the master, EX the slave.
interface id_stage_if;
    logic [31:0] Rdata1;
    logic [31:0] Rdata2;
    logic [5:0]  ALU;
    logic [5:0]  Op;
    logic [31:0] Ed32;
    logic [25:0] Jadr;
    logic [31:0] nextPC;
    logic [4:0]  Dst;
    logic        RegWrite;
    logic        Valid;

    modport master (
        output Rdata1, Rdata2, ALU, Op, Ed32, Jadr, nextPC, Dst, RegWrite, Valid
    );
    modport slave (
        input Rdata1, Rdata2, ALU, Op, Ed32, Jadr, nextPC, Dst, RegWrite, Valid
    );
endinterface

// File: rtl/mips_regfile.sv
// 32x32 register file: two async read ports with write-through bypass, one sync write
// port, synchronous clear. $0 reads as zero and is never written.
module mips_regfile #(
    parameter int unsigned NREG = 32,
    parameter int unsigned W    = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [4:0]   i_radr1,
    input  logic [4:0]   i_radr2,
    output logic [W-1:0] o_rdata1,
    output logic [W-1:0] o_rdata2,
    input  logic         i_wen,
    input  logic [4:0]   i_wadr,
    input  logic [W-1:0] i_wdata
);

    logic [W-1:0] r_regs [NREG];
    logic         w_wr;

    assign w_wr = i_wen && (i_wadr != 5'd0) && !i_rst;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr) begin
            r_regs[i_wadr] <= i_wdata;
        end
    end

    // Bypass lets a WB and an ID of the same register in one cycle see the new value.
    always_comb begin
        o_rdata1 = '0;
        o_rdata2 = '0;
        if (i_radr1 != 5'd0) begin
            o_rdata1 = (w_wr && (i_wadr == i_radr1)) ? i_wdata : r_regs[i_radr1];
        end
        if (i_radr2 != 5'd0) begin
            o_rdata2 = (w_wr && (i_wadr == i_radr2)) ? i_wdata : r_regs[i_radr2];
        end
    end

endmodule

// File: rtl/id_stage.sv
// MIPS instruction-decode stage: decodes Ins, reads the register file and registers the
// result into the ID/EX latch driving the EX input bus.
module id_stage
    import mips_pkg::*;
#(
    parameter int unsigned NREG = 32,
    parameter int unsigned W    = 32
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic [31:0]    Ins,
    input  logic [W-1:0]   nextPC_in,
    input  logic           Valid_in,
    input  logic           Hold,
    input  logic           Flush,
    input  logic           Wen,
    input  logic [4:0]     Wadr,
    input  logic [W-1:0]   Wdata,
    id_stage_if.master     ex
);

    logic [5:0]   w_op;
    logic [5:0]   w_funct;
    logic [4:0]   w_rs;
    logic [4:0]   w_rt;
    logic [4:0]   w_rd;
    logic [4:0]   w_shamt;
    logic [15:0]  w_imm;
    logic [W-1:0] w_rf_rdata1;
    logic [W-1:0] w_rf_rdata2;
    logic         w_is_shift;
    idex_t        w_idex_d;
    idex_t        r_idex;

    assign w_op    = Ins[31:26];
    assign w_rs    = Ins[25:21];
    assign w_rt    = Ins[20:16];
    assign w_rd    = Ins[15:11];
    assign w_shamt = Ins[10:6];
    assign w_funct = Ins[5:0];
    assign w_imm   = Ins[15:0];

    mips_regfile #(
        .NREG (NREG),
        .W    (W)
    ) u_regfile (
        .i_clk    (CLK),
        .i_rst    (RST),
        .i_radr1  (w_rs),
        .i_radr2  (w_rt),
        .o_rdata1 (w_rf_rdata1),
        .o_rdata2 (w_rf_rdata2),
        .i_wen    (Wen),
        .i_wadr   (Wadr),
        .i_wdata  (Wdata)
    );

    always_comb begin
        w_is_shift = (w_op == OP_RTYPE) && (w_funct inside {F_SLL, F_SRL, F_SRA});

        w_idex_d         = '0;
        w_idex_d.rdata1  = w_is_shift ? {27'b0, w_shamt} : w_rf_rdata1;
        w_idex_d.rdata2  = w_rf_rdata2;
        w_idex_d.op      = w_op;
        w_idex_d.alu     = (w_op == OP_RTYPE) ? w_funct : w_op;
        w_idex_d.ed32    = is_zext_imm(w_op) ? {16'b0, w_imm} : {{16{w_imm[15]}}, w_imm};
        w_idex_d.jadr    = Ins[25:0];
        w_idex_d.next_pc = nextPC_in;
        w_idex_d.valid   = 1'b1;

        if (w_op == OP_RTYPE) begin
            w_idex_d.dst = w_rd;
        end else if (w_op == OP_JAL) begin
            w_idex_d.dst = REG_RA;
        end else begin
            w_idex_d.dst = w_rt;
        end

        w_idex_d.reg_write = writes_reg(w_op, w_funct) && (w_idex_d.dst != 5'd0);
    end

    // A load with Valid_in low is a bubble, same as Flush.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_idex <= '0;
        end else if (Flush) begin
            r_idex <= '0;
        end else if (!Hold) begin
            r_idex <= Valid_in ? w_idex_d : '0;
        end
    end

    assign ex.Rdata1   = r_idex.rdata1;
    assign ex.Rdata2   = r_idex.rdata2;
    assign ex.ALU      = r_idex.alu;
    assign ex.Op       = r_idex.op;
    assign ex.Ed32     = r_idex.ed32;
    assign ex.Jadr     = r_idex.jadr;
    assign ex.nextPC   = r_idex.next_pc;
    assign ex.Dst      = r_idex.dst;
    assign ex.RegWrite = r_idex.reg_write;
    assign ex.Valid    = r_idex.valid;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: stimulus pushes hand-computed expectations tagged with
// the cycle they must appear; a negedge monitor pops and compares.
module tb_id_stage;

    typedef struct packed {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [5:0]  alu;
        logic [5:0]  op;
        logic [31:0] ed;
        logic [25:0] jadr;
        logic [31:0] npc;
        logic [4:0]  dst;
        logic        rw;
        logic        v;
    } out_t;

    typedef struct {
        int    cyc;
        string name;
        out_t  val;
    } exp_t;

    logic        CLK;
    logic        RST;
    logic [31:0] Ins;
    logic [31:0] nextPC_in;
    logic        Valid_in;
    logic        Hold;
    logic        Flush;
    logic        Wen;
    logic [4:0]  Wadr;
    logic [31:0] Wdata;

    id_stage_if ex ();

    id_stage #(
        .NREG (32),
        .W    (32)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .Ins       (Ins),
        .nextPC_in (nextPC_in),
        .Valid_in  (Valid_in),
        .Hold      (Hold),
        .Flush     (Flush),
        .Wen       (Wen),
        .Wadr      (Wadr),
        .Wdata     (Wdata),
        .ex        (ex)
    );

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    out_t zero_o = '0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic out_t mk(logic [31:0] rd1, logic [31:0] rd2, logic [5:0] alu,
                                logic [5:0] op, logic [31:0] ed, logic [25:0] jadr,
                                logic [31:0] npc, logic [4:0] dst, logic rw, logic v);
        out_t o;
        o = '{rd1: rd1, rd2: rd2, alu: alu, op: op, ed: ed, jadr: jadr, npc: npc,
              dst: dst, rw: rw, v: v};
        return o;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(logic [31:0] ins, logic [31:0] npc, logic vin, logic hold,
                         logic flush, logic wen, logic [4:0] wadr, logic [31:0] wdata);
        Ins = ins; nextPC_in = npc; Valid_in = vin; Hold = hold; Flush = flush;
        Wen = wen; Wadr = wadr; Wdata = wdata;
    endtask

    // Expectation applies to the outputs after the next active edge.
    task automatic expect_next(string name, out_t val);
        exp_t e;
        e.cyc  = cyc + 1;
        e.name = name;
        e.val  = val;
        sb.push_back(e);
        step();
    endtask

    always @(negedge CLK) begin
        out_t got;
        got = '{rd1: ex.Rdata1, rd2: ex.Rdata2, alu: ex.ALU, op: ex.Op, ed: ex.Ed32,
                jadr: ex.Jadr, npc: ex.nextPC, dst: ex.Dst, rw: ex.RegWrite, v: ex.Valid};
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL %s: expectation for cycle %0d never compared (now %0d)",
                     sb[0].name, sb[0].cyc, cyc);
            void'(sb.pop_front());
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            checks++;
            if (got !== sb[0].val) begin
                errors++;
                $display("FAIL %s: got rd1=%h rd2=%h alu=%h op=%h ed=%h jadr=%h npc=%h dst=%0d rw=%b v=%b | want rd1=%h rd2=%h alu=%h op=%h ed=%h jadr=%h npc=%h dst=%0d rw=%b v=%b",
                         sb[0].name,
                         got.rd1, got.rd2, got.alu, got.op, got.ed, got.jadr, got.npc,
                         got.dst, got.rw, got.v,
                         sb[0].val.rd1, sb[0].val.rd2, sb[0].val.alu, sb[0].val.op,
                         sb[0].val.ed, sb[0].val.jadr, sb[0].val.npc, sb[0].val.dst,
                         sb[0].val.rw, sb[0].val.v);
            end
            void'(sb.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        RST = 1'b1;
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        step();
        // Reset with a live instruction and a WB write that must be ignored.
        drive(32'h00A51820, 32'h10, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 32'hDEAD);
        expect_next("reset", zero_o);
        RST = 1'b0;

        // ADD $3,$5,$5 : reg5 must still be 0
        drive(32'h00A51820, 32'h10, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        expect_next("add_after_reset",
                    mk(32'h0, 32'h0, 6'h20, 6'h00, 32'h00001820, 26'h0A51820, 32'h10, 5'd3, 1'b1, 1'b1));

        // Bubble while WB writes reg5
        drive(32'h00A51820, 32'h14, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h1234);
        expect_next("bubble", zero_o);

        drive(32'h00A51820, 32'h14, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        expect_next("add_r5",
                    mk(32'h1234, 32'h1234, 6'h20, 6'h00, 32'h00001820, 26'h0A51820, 32'h14, 5'd3, 1'b1, 1'b1));

        // ADDI $8,$7,-1 with same-cycle WB of reg7
        drive(32'h20E8FFFF, 32'h18, 1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 32'hA5);
        expect_next("addi_bypass",
                    mk(32'hA5, 32'h0, 6'h08, 6'h08, 32'hFFFFFFFF, 26'h0E8FFFF, 32'h18, 5'd8, 1'b1, 1'b1));

        // ORI $8,$7,0x8000 : zero-extended, reg7 now stored
        drive(32'h34E88000, 32'h1C, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        expect_next("ori_zext",
                    mk(32'hA5, 32'h0, 6'h0D, 6'h0D, 32'h00008000, 26'h0E88000, 32'h1C, 5'd8, 1'b1, 1'b1));

        // SLL $2,$4,5 with same-cycle WB of reg4 on the rt port
        drive(32'h00041140, 32'h20, 1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 32'hCAFE);
        expect_next("sll_shamt",
                    mk(32'h5, 32'hCAFE, 6'h00, 6'h00, 32'h00001140, 26'h0041140, 32'h20, 5'd2, 1'b1, 1'b1));

        // ADD $3,$0,$0 while WB targets $0 : no bypass on $0
        drive(32'h00001820, 32'h24, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'h9);
        expect_next("r0_no_bypass",
                    mk(32'h0, 32'h0, 6'h20, 6'h00, 32'h00001820, 26'h0001820, 32'h24, 5'd3, 1'b1, 1'b1));

        // ADD $3,$0,$4 : $0 stayed 0, reg4 persisted
        drive(32'h00041820, 32'h28, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        expect_next("r0_stays_zero",
                    mk(32'h0, 32'hCAFE, 6'h20, 6'h00, 32'h00001820, 26'h0041820, 32'h28, 5'd3, 1'b1, 1'b1));

        // JAL 0x100
        drive(32'h0C000100, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        expect_next("jal",
                    mk(32'h0, 32'h0, 6'h03, 6'h03, 32'h00000100, 26'h0000100, 32'h40, 5'd31, 1'b1, 1'b1));

        for (int i = 0; i < 3; i++) begin
            drive(32'h00A51820 + i, 32'h99 + i, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
            expect_next($sformatf("hold_%0d", i),
                        mk(32'h0, 32'h0, 6'h03, 6'h03, 32'h00000100, 26'h0000100, 32'h40, 5'd31, 1'b1, 1'b1));
        end

        drive(32'h00A51820, 32'h44, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
        expect_next("hold_and_flush", zero_o);

        // MULT with nonzero rd field must not write
        drive(32'h00A43018, 32'h44, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        expect_next("mult_norw",
                    mk(32'h1234, 32'hCAFE, 6'h18, 6'h00, 32'h00003018, 26'h0A43018, 32'h44, 5'd6, 1'b0, 1'b1));

        // JR $5 with rd=31
        drive(32'h00A0F808, 32'h48, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        expect_next("jr_norw",
                    mk(32'h1234, 32'h0, 6'h08, 6'h00, 32'hFFFFF808, 26'h0A0F808, 32'h48, 5'd31, 1'b0, 1'b1));

        // Unknown opcode 0x3f
        drive(32'hFCA40001, 32'h4C, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        expect_next("unknown_op",
                    mk(32'h1234, 32'hCAFE, 6'h3F, 6'h3F, 32'h00000001, 26'h0A40001, 32'h4C, 5'd4, 1'b0, 1'b1));

        // LW $0,4($5) : load to $0 never writes
        drive(32'h8CA00004, 32'h50, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        expect_next("lw_to_r0",
                    mk(32'h1234, 32'h0, 6'h23, 6'h23, 32'h00000004, 26'h0A00004, 32'h50, 5'd0, 1'b0, 1'b1));

        drive(32'h00A51820, 32'h54, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
        expect_next("flush", zero_o);

        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        step();
        step();
        step();
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
